// File: rtl/sync_pkg.sv
// Shared limits and edge-detect helper for the level synchronizer.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;
  localparam int SYNC_MAX_STAGES = 4;

  typedef struct packed {
    logic rise;
    logic fall;
  } sync_edge_t;

  function automatic sync_edge_t sync_edge(input logic cur, input logic prev);
    sync_edge_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/sync_stage_chain.sv
// Bare multi-flop synchronizer chain: STAGES flops per bit, nothing between them.
// Output is the last flop; each bit is synchronized independently.
module sync_stage_chain
  import sync_pkg::*;
#(
  parameter int                 WIDTH       = 1,
  parameter int                 STAGES      = 2,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Async_i,
  output logic [WIDTH-1:0] Sync_o
);

  // Attributes keep placement tight and stop retiming/merging across the chain.
  (* ASYNC_REG = "TRUE", dont_touch = "true" *)
  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = Async_i;
    for (int k = 1; k < STAGES; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= RESET_VALUE;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign Sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/synchronizer.sv
// Level synchronizer with single-cycle rise/fall strobes on the synchronized level.
// Strobes come only from flops, so Async_i has no combinational path to any output.
module synchronizer
  import sync_pkg::*;
#(
  parameter int               STAGES      = 2,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Async_i,
  output logic [WIDTH-1:0] Sync_o,
  output logic [WIDTH-1:0] Rise_o,
  output logic [WIDTH-1:0] Fall_o
);

  if (STAGES < SYNC_MIN_STAGES || STAGES > SYNC_MAX_STAGES) begin : g_bad_stages
    $error("synchronizer: STAGES=%0d outside legal range %0d..%0d",
           STAGES, SYNC_MIN_STAGES, SYNC_MAX_STAGES);
  end

  logic [WIDTH-1:0] chain_sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] prev_d;
  sync_edge_t       edge_tmp;

  sync_stage_chain #(
    .WIDTH       (WIDTH),
    .STAGES      (STAGES),
    .RESET_VALUE (RESET_VALUE)
  ) u_chain (
    .Clock   (Clock),
    .Reset   (Reset),
    .Async_i (Async_i),
    .Sync_o  (chain_sync)
  );

  assign prev_d = chain_sync;

  // History shares the chain's reset value so no strobe can fire on reset release.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      prev_q <= RESET_VALUE;
    end else begin
      prev_q <= prev_d;
    end
  end

  always_comb begin
    Rise_o   = '0;
    Fall_o   = '0;
    edge_tmp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_tmp  = sync_edge(chain_sync[i], prev_q[i]);
      Rise_o[i] = edge_tmp.rise;
      Fall_o[i] = edge_tmp.fall;
    end
  end

  assign Sync_o = chain_sync;

endmodule

// File: tb/tb_synchronizer.sv
// Directed and randomized checks of synchronizer against a sample-history reference model.
`timescale 1ns/1ps
module tb_synchronizer;

  localparam int ST1 = 2;
  localparam int ST4 = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [0:0] a1;
  logic [3:0] a4;
  logic [0:0] s1, r1, f1;
  logic [3:0] s4, r4, f4;

  int checks   = 0;
  int failures = 0;

  always #50 clk = ~clk;

  synchronizer #(.STAGES(ST1), .WIDTH(1), .RESET_VALUE(1'b0)) u1 (
    .Clock(clk), .Reset(rst), .Async_i(a1), .Sync_o(s1), .Rise_o(r1), .Fall_o(f1)
  );

  synchronizer #(.STAGES(ST4), .WIDTH(4), .RESET_VALUE(4'h0)) u4 (
    .Clock(clk), .Reset(rst), .Async_i(a4), .Sync_o(s4), .Rise_o(r4), .Fall_o(f4)
  );

  // Reference: input values seen at each rising edge since the last reset.
  // The output after edge m is the sample from edge m-STAGES+1 (reset value before that).
  logic [0:0] h1[$];
  logic [3:0] h4[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1.delete();
      h4.delete();
    end else begin
      h1.push_back(a1);
      h4.push_back(a4);
    end
  end

  function automatic logic [0:0] m1(int m);
    if (m < ST1) return 1'b0;
    return h1[m-ST1];
  endfunction

  function automatic logic [3:0] m4(int m);
    if (m < ST4) return 4'h0;
    return h4[m-ST4];
  endfunction

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    int n1;
    int n4;
    logic [0:0] c1, p1;
    logic [3:0] c4, p4;
    n1 = h1.size();
    n4 = h4.size();
    c1 = m1(n1);
    p1 = m1(n1 - 1);
    c4 = m4(n4);
    p4 = m4(n4 - 1);
    chk({tag, ".sync1"}, {3'b0, s1}, {3'b0, c1});
    chk({tag, ".rise1"}, {3'b0, r1}, {3'b0, c1 & ~p1});
    chk({tag, ".fall1"}, {3'b0, f1}, {3'b0, ~c1 & p1});
    chk({tag, ".sync4"}, s4, c4);
    chk({tag, ".rise4"}, r4, c4 & ~p4);
    chk({tag, ".fall4"}, f4, ~c4 & p4);
  endtask

  initial begin
    int hi, nr, nf, rise_at, fall_at;

    // Reset held with input high: outputs stay at reset value.
    a1 = 1'b1;
    a4 = 4'hF;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_all("t1_reset");
      chk("t1_sync_zero", {3'b0, s1}, 4'h0);
    end
    a1 = 1'b0;
    a4 = 4'h0;
    #20 rst = 1'b0;

    // Pulse covering 4 edges, starting 75 ns after an edge.
    @(posedge clk);
    fork
      begin #75 a1 = 1'b1; #353 a1 = 1'b0; end
    join_none
    hi = 0; nr = 0; nf = 0; rise_at = -1; fall_at = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_all("t2");
      hi += int'(s1);
      nr += int'(r1);
      nf += int'(f1);
      if (r1 == 1'b1 && rise_at < 0) rise_at = i;
      if (f1 == 1'b1 && fall_at < 0) fall_at = i;
    end
    chk_int("t2_rise_cycle", rise_at, 2);
    chk_int("t2_fall_cycle", fall_at, 6);
    chk_int("t2_high_3to4", int'(hi >= 3 && hi <= 4), 1);
    chk_int("t2_rise_count", nr, 1);
    chk_int("t2_fall_count", nf, 1);

    // Pulse starting just after an edge; also sampled late in each cycle so a
    // mid-cycle change of Sync_o would be seen.
    @(posedge clk);
    fork
      begin #110 a1 = 1'b1; #456 a1 = 1'b0; end
    join_none
    hi = 0; nr = 0; nf = 0;
    repeat (10) begin
      @(negedge clk);
      check_all("t3_mid");
      hi += int'(s1);
      nr += int'(r1);
      nf += int'(f1);
      #49 check_all("t3_late");
    end
    chk_int("t3_high_4to5", int'(hi >= 4 && hi <= 5), 1);
    chk_int("t3_rise_count", nr, 1);
    chk_int("t3_fall_count", nf, 1);

    // Glitch between edges is never sampled.
    @(negedge clk);
    #10 a1 = 1'b1;
    #30 a1 = 1'b0;
    hi = 0; nr = 0; nf = 0;
    repeat (4) begin
      @(negedge clk);
      check_all("t4");
      hi += int'(s1);
      nr += int'(r1);
      nf += int'(f1);
    end
    chk_int("t4_high", hi, 0);
    chk_int("t4_strobes", nr + nf, 0);

    // Asynchronous reset while Sync_o is high, then release with input high.
    @(negedge clk);
    a1 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_all("t5_pre");
    end
    chk("t5_sync_high", {3'b0, s1}, 4'h1);
    #20 rst = 1'b1;
    #1;
    check_all("t5_async");
    chk("t5_sync_cleared", {3'b0, s1}, 4'h0);
    chk("t5_no_fall", {3'b0, f1}, 4'h0);
    @(negedge clk);
    check_all("t5_held");
    #20 rst = 1'b0;
    nr = 0; nf = 0; rise_at = -1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_all("t5_post");
      nr += int'(r1);
      nf += int'(f1);
      if (r1 == 1'b1 && rise_at < 0) rise_at = i;
    end
    chk_int("t5_rise_cycle", rise_at, 1);
    chk_int("t5_rise_count", nr, 1);
    chk_int("t5_fall_count", nf, 0);

    // Wide, three-stage instance.
    @(negedge clk);
    #10 a4 = 4'b1010;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_all("t6");
      chk($sformatf("t6_sync_e%0d", i), s4, (i >= 3) ? 4'b1010 : 4'b0000);
      chk($sformatf("t6_rise_e%0d", i), r4, (i == 3) ? 4'b1010 : 4'b0000);
    end

    // Random levels, mid-cycle glitches and occasional asynchronous resets.
    repeat (400) begin
      @(negedge clk);
      check_all("rnd");
      if (rst) begin
        #15 rst = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        #15 rst = 1'b1;
        #1 check_all("rnd_rst");
      end
      #($urandom_range(2, 20));
      a1 = 1'($urandom);
      a4 = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        #5;
        a1 = ~a1;
        a4 = 4'($urandom);
      end
    end
    @(negedge clk);
    check_all("rnd_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
